// File: rtl/mul_cell_seq.sv
// mul_cell_seq
//   Sequencer between the Nios execute stage and the three-product 16x16
//   multiplier cell. It takes one 32x32 multiply request at a time and drives
//   the cell operands and enable. It then folds the lo*lo, lo*hi and hi*lo
//   partial products into a result. High-word ops (MULXUU/MULXSS/MULXSU) make
//   a second cell pass on the upper halves to obtain hi*hi. The 32-bit result
//   is returned over a valid/ready handshake.
//
// Ports
//   clk, reset              clock; asynchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_op                  0=MUL (low word), 1=MULXUU, 2=MULXSS, 3=MULXSU
//   req_a, req_b            32-bit operands
//   flush                   abort the in-flight op; no response is produced
//   rsp_valid/rsp_ready     response handshake
//   rsp_data                32-bit result, stable while rsp_valid is high
//   cell_src1/2, cell_en    registered operands and enable to the cell
//   cell_p1/p2/p3           cell products lo*lo, lo*hi, hi*lo (valid one
//                           clock after cell_en)
//
// Parameter
//   HI_EN  1 = high-word ops supported; 0 = every op executes as MUL
module mul_cell_seq #(
    parameter int HI_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        CAP1   = 3'd2,
        ISSUE2 = 3'd3,
        CAP2   = 3'd4,
        DONE   = 3'd5
    } state_t;

    // Low pass: p1 + ((p2 + p3) << 16). The cross-term sum needs 33 bits and
    // the full result 50 bits; bits [49:32] carry into the high word.
    function automatic logic [49:0] lo_combine(input logic [31:0] p1,
                                               input logic [31:0] p2,
                                               input logic [31:0] p3);
        logic [32:0] mid;
        mid = {1'b0, p2} + {1'b0, p3};
        return {18'd0, p1} + ({17'd0, mid} << 16);
    endfunction

    // High pass: hi*hi plus the carry from the low pass gives the unsigned
    // high word. A negative signed operand contributes -(other operand) * 2^32
    // to the 64-bit product, so the signed variants subtract the other operand.
    function automatic logic [31:0] hi_combine(input logic [31:0] hh,
                                               input logic [17:0] carry,
                                               input logic [1:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [31:0] hi_u;
        logic [31:0] corr_a;
        logic [31:0] corr_b;
        hi_u   = hh + {14'd0, carry};
        corr_a = a[31] ? b : 32'd0;
        corr_b = b[31] ? a : 32'd0;
        case (op)
            2'd2:    return hi_u - corr_a - corr_b;
            2'd3:    return hi_u - corr_a;
            default: return hi_u;
        endcase
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  op_q;
    logic [17:0] acc_hi;
    logic [49:0] lo_acc;
    logic [31:0] hi_res;
    logic        accept;

    assign req_ready = (state == IDLE) && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == DONE);
    assign lo_acc    = lo_combine(cell_p1, cell_p2, cell_p3);
    assign hi_res    = hi_combine(cell_p1, acc_hi, op_q, a_q, b_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE1;
            ISSUE1:  state_nxt = CAP1;
            CAP1:    state_nxt = (op_q == 2'd0) ? DONE : ISSUE2;
            ISSUE2:  state_nxt = CAP2;
            CAP2:    state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            acc_hi    <= '0;
            rsp_data  <= '0;
            cell_en   <= 1'b0;
            cell_src1 <= '0;
            cell_src2 <= '0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                a_q  <= req_a;
                b_q  <= req_b;
                op_q <= (HI_EN != 0) ? req_op : 2'd0;
            end

            // Cell controls are registered from the next state so they are
            // asserted exactly while the FSM sits in an ISSUE state. ISSUE1 is
            // only reachable from an accept, so its operands come straight
            // from the request port.
            cell_en <= (state_nxt == ISSUE1) || (state_nxt == ISSUE2);
            if (state_nxt == ISSUE1) begin
                cell_src1 <= req_a;
                cell_src2 <= req_b;
            end else if (state_nxt == ISSUE2) begin
                cell_src1 <= {16'h0, a_q[31:16]};
                cell_src2 <= {16'h0, b_q[31:16]};
            end else begin
                cell_src1 <= '0;
                cell_src2 <= '0;
            end

            if (state == CAP1 && !flush) begin
                acc_hi <= lo_acc[49:32];
                if (op_q == 2'd0) rsp_data <= lo_acc[31:0];
            end

            if (state == CAP2 && !flush) rsp_data <= hi_res;
        end
    end

endmodule

// File: tb/tb_mul_cell_seq.sv
// Testbench for mul_cell_seq: one instance with high-word ops enabled and one
// with HI_EN=0, each driving a behavioural model of the 16x16 product cell.
module tb_mul_cell_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1 = '0;
    logic [31:0] cell_p2 = '0;
    logic [31:0] cell_p3 = '0;

    logic        req_valid0;
    logic        req_ready0;
    logic        flush0;
    logic        rsp_valid0;
    logic        rsp_ready0;
    logic [31:0] rsp_data0;
    logic [31:0] cell0_src1;
    logic [31:0] cell0_src2;
    logic        cell0_en;
    logic [31:0] cell0_p1 = '0;
    logic [31:0] cell0_p2 = '0;
    logic [31:0] cell0_p3 = '0;

    int vectors     = 0;
    int miscompares = 0;

    mul_cell_seq #(.HI_EN(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
        .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3)
    );

    mul_cell_seq #(.HI_EN(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .cell_src1(cell0_src1), .cell_src2(cell0_src2), .cell_en(cell0_en),
        .cell_p1(cell0_p1), .cell_p2(cell0_p2), .cell_p3(cell0_p3)
    );

    // Product cell: captures operands on an enabled edge, holds otherwise.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'd0, cell_src1[15:0]}  * {16'd0, cell_src2[15:0]};
            cell_p2 <= {16'd0, cell_src1[15:0]}  * {16'd0, cell_src2[31:16]};
            cell_p3 <= {16'd0, cell_src1[31:16]} * {16'd0, cell_src2[15:0]};
        end
        if (cell0_en) begin
            cell0_p1 <= {16'd0, cell0_src1[15:0]}  * {16'd0, cell0_src2[15:0]};
            cell0_p2 <= {16'd0, cell0_src1[15:0]}  * {16'd0, cell0_src2[31:16]};
            cell0_p3 <= {16'd0, cell0_src1[31:16]} * {16'd0, cell0_src2[15:0]};
        end
    end

    // Reference: full 64-bit product of the operands interpreted per op.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit hi_en);
        logic [63:0] ua, ub, sa, sb, prod;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!hi_en || op == 2'd0) begin
            prod = ua * ub;
            return prod[31:0];
        end
        case (op)
            2'd1:    prod = ua * ub;
            2'd2:    prod = sa * sb;
            default: prod = sa * ub;
        endcase
        return prod[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_accept: req_ready=%b expected 1", tag, req_ready);
        end
    endtask

    // Follows an op accepted at the edge after the last negedge; returns at
    // the negedge where rsp_valid is first seen, response not yet consumed.
    task automatic follow(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int          lat;
        int          lat_exp;
        logic [7:0]  en_mask;
        logic [7:0]  en_exp;
        logic [31:0] es1, es2;
        lat     = 0;
        en_mask = '0;
        lat_exp = (op == 2'd0) ? 3 : 5;
        en_exp  = (op == 2'd0) ? 8'b0000_0010 : 8'b0000_1010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (cell_en === 1'b1) begin
                if (k < 8) en_mask[k] = 1'b1;
                es1 = (k == 3) ? {16'h0, a[31:16]} : a;
                es2 = (k == 3) ? {16'h0, b[31:16]} : b;
                vectors++;
                if (cell_src1 !== es1 || cell_src2 !== es2) begin
                    miscompares++;
                    $display("FAIL %s_src cycle %0d: src1=%h src2=%h expected %h %h",
                             tag, k, cell_src1, cell_src2, es1, es2);
                end
            end
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        vectors++;
        if (lat != lat_exp) begin
            miscompares++;
            $display("FAIL %s_latency: rsp_valid at cycle %0d expected %0d", tag, lat, lat_exp);
        end
        vectors++;
        if (en_mask !== en_exp) begin
            miscompares++;
            $display("FAIL %s_cell_en: pulse mask %b expected %b", tag, en_mask, en_exp);
        end
        vectors++;
        if (rsp_data !== exp) begin
            miscompares++;
            $display("FAIL %s_data: op=%0d a=%h b=%h rsp_data=%h expected %h",
                     tag, op, a, b, rsp_data, exp);
        end
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_consume: rsp_valid=%b req_ready=%b expected 0 1",
                     tag, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; flush = 0;
        rsp_ready = 0; req_valid0 = 0; flush0 = 0; rsp_ready0 = 1'b1;
        #12;
        vectors++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b expected 0 0", req_ready, rsp_valid);
        end
        vectors++;
        if (cell_en !== 1'b0 || cell_src1 !== 32'd0 || cell_src2 !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cell: en=%b src1=%h src2=%h expected 0", cell_en, cell_src1, cell_src2);
        end
        vectors++;
        if (rsp_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: rsp_data=%h expected 0", rsp_data);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || req_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: req_ready=%b req_ready0=%b expected 1 1", req_ready, req_ready0);
        end
    endtask

    task automatic test_directed();
        issue(2'd0, 32'h0001_0003, 32'h0002_0005, "mul");
        follow(2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "mul");
        consume("mul");
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulxuu");
        follow(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulxuu");
        consume("mulxuu");
        issue(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, "mulxss");
        follow(2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulxss");
        consume("mulxss");
        issue(2'd3, 32'h8000_0000, 32'h8000_0000, "mulxsu");
        follow(2'd3, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, "mulxsu");
        consume("mulxsu");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            issue(op, a, b, "rand");
            follow(op, a, b, ref_mul(op, a, b, 1'b1), "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
            consume("rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, exp1;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        exp1 = ref_mul(2'd1, a1, b1, 1'b1);
        issue(2'd1, a1, b1, "bp1");
        follow(2'd1, a1, b1, exp1, "bp1");
        req_valid = 1'b1; req_op = 2'd0; req_a = a2; req_b = b2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp1 || req_ready !== 1'b0 || cell_en !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold %0d: rsp_valid=%b rsp_data=%h req_ready=%b cell_en=%b expected 1 %h 0 0",
                         i, rsp_valid, rsp_data, req_ready, cell_en, exp1);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
        end
        follow(2'd0, a2, b2, ref_mul(2'd0, a2, b2, 1'b1), "bp2");
        consume("bp2");
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_a = 32'd7; req_b = 32'd9; flush = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_ready: req_ready=%b expected 0", req_ready);
        end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        vectors++;
        if (cell_en !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_accept: cell_en=%b expected 0", cell_en);
        end
        @(negedge clk);
        vectors++;
        if (cell_en !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_quiet: cell_en=%b rsp_valid=%b expected 0 0", cell_en, rsp_valid);
        end
    endtask

    task automatic test_flush();
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "flush");
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (cell_en !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_issue2: cell_en=%b expected 1", cell_en);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cell_en !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_abort: rsp_valid=%b req_ready=%b cell_en=%b expected 0 1 0",
                     rsp_valid, req_ready, cell_en);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_rsp %0d: rsp_valid=%b expected 0", i, rsp_valid);
            end
        end
        issue(2'd0, 32'd3, 32'd5, "post_flush");
        follow(2'd0, 32'd3, 32'd5, 32'h0000_000F, "post_flush");
        consume("post_flush");
    endtask

    task automatic test_async_reset();
        logic [31:0] a, b;
        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, "areset");
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || cell_en !== 1'b0 || rsp_data !== 32'd0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_clear: rsp_valid=%b cell_en=%b rsp_data=%h req_ready=%b expected 0 0 0 0",
                     rsp_valid, cell_en, rsp_data, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_release: req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid);
        end
        a = $urandom; b = $urandom;
        issue(2'd2, a, b, "areset_after");
        follow(2'd2, a, b, ref_mul(2'd2, a, b, 1'b1), "areset_after");
        consume("areset_after");
    endtask

    task automatic test_hi_disabled();
        logic [1:0]  op;
        logic [31:0] a, b, exp, got;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                op = 2'd3; a = 32'h8000_0000; b = 32'h8000_0000;
            end else begin
                op = 2'($urandom_range(0, 3)); a = pick_operand(); b = pick_operand();
            end
            exp = ref_mul(op, a, b, 1'b0);
            @(negedge clk);
            req_valid0 = 1'b1; req_op = op; req_a = a; req_b = b;
            lat = 0;
            got = '0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (k == 1) req_valid0 = 1'b0;
                if (rsp_valid0 === 1'b1) begin
                    lat = k;
                    got = rsp_data0;
                    break;
                end
            end
            vectors++;
            if (lat != 3 || got !== exp) begin
                miscompares++;
                $display("FAIL hi_disabled %0d: op=%0d a=%h b=%h latency=%0d data=%h expected 3 %h",
                         i, op, a, b, lat, got, exp);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush_idle();
        test_flush();
        test_async_reset();
        test_hi_disabled();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_cell_seq.md
Name: mul_cell_seq

Overview:
- Sequencer that sits between the Nios execute stage and the three-product 16x16 multiplier cell.
- The cell returns lo*lo, lo*hi and hi*lo products one clock after its enable.
- This block accepts one 32x32 multiply request at a time, drives the cell operands and enable, and combines the partial products.
- For high-word ops it makes a second cell pass to obtain hi*hi, then returns the 32-bit result over a valid/ready handshake.

Parameters:
- HI_EN, 1, 1 = support MULXUU/MULXSS/MULXSU; 0 = every op is executed as MUL (single pass).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  0=MUL (low 32), 1=MULXUU, 2=MULXSS, 3=MULXSU (high 32)
- req_a  in  32  operand A
- req_b  in  32  operand B
- flush  in  1  abort any in-flight op; no response is produced
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result
- cell_src1  out  32  to cell E_src1
- cell_src2  out  32  to cell E_src2
- cell_en  out  1  to cell M_en
- cell_p1  in  32  cell lo(a)*lo(b)
- cell_p2  in  32  cell lo(a)*hi(b)
- cell_p3  in  32  cell hi(a)*lo(b)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; while asserted all registers clear immediately.
- Reset values: state=IDLE, req_ready=0 during reset (1 once in IDLE), rsp_valid=0, rsp_data=0, cell_en=0, cell_src1/2=0, internal accumulator=0.
- States: IDLE, ISSUE1, CAP1, ISSUE2, CAP2, DONE.
- IDLE:
  - req_ready = ~flush.
  - On req_valid&req_ready, latch a, b and op, then go to ISSUE1.
  - With HI_EN=0, the latched op is forced to 0.
- ISSUE1:
  - cell_src1=a, cell_src2=b, cell_en=1 for exactly one cycle; go to CAP1.
- CAP1 (cell products valid):
  - acc[49:0] = p1 + ((p2+p3) << 16), where p2+p3 is a 33-bit sum.
  - If op==0: rsp_data <= acc[31:0], go to DONE.
  - Otherwise: store acc, go to ISSUE2.
- ISSUE2:
  - cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1; go to CAP2.
- CAP2:
  - hi_u = p1 + acc[49:32], mod 2^32.
  - op1: rsp_data <= hi_u.
  - op2: rsp_data <= hi_u - (a[31]?b:0) - (b[31]?a:0).
  - op3: rsp_data <= hi_u - (a[31]?b:0).
  - All results mod 2^32; go to DONE.
- DONE:
  - rsp_valid=1; rsp_data held stable until rsp_ready.
  - On rsp_ready, rsp_valid drops next cycle and the state returns to IDLE.
- Handshakes:
  - req_ready is 0 in every state except IDLE; a new request is accepted no earlier than the cycle after the response handshake.
  - Response latency from the accept edge: MUL, rsp_valid at cycle +3; high ops, cycle +5.
- cell_en is 0 in every state other than ISSUE1/ISSUE2, so the cell holds its outputs.
- cell_src1/2 are registered, and are 0 outside the ISSUE states.
- Flush:
  - In any non-IDLE state: next state IDLE, rsp_valid=0, any pending result discarded, cell_en=0.
  - In IDLE: blocks the accept that cycle.
  - flush together with rsp_ready in DONE: the flush is applied; the response counts as consumed.
- Mid-operation reset behaves like flush, but also clears rsp_data and acc.
- Overflow: MUL discards bits above 31; no overflow flags.

Test Plan:
- MUL a=0x00010003, b=0x00020005 -> cell_en pulses once (cycle +1); rsp_valid at +3; rsp_data=0x000B000F.
- MULXUU a=b=0xFFFFFFFF -> cell_en pulses at +1 and +3; second pass drives cell_src1=cell_src2=0x0000FFFF; rsp_data=0xFFFFFFFE at +5.
- Signed high ops:
  - MULXSS a=0xFFFFFFFF, b=0x00000002 -> rsp_data=0xFFFFFFFF.
  - MULXSU a=0x80000000, b=0x80000000 -> rsp_data=0xC0000000.
  - With HI_EN=0, the same MULXSU returns 0x00000000 at +3.
- Backpressure: hold rsp_ready=0 for 4 cycles after rsp_valid -> rsp_valid/rsp_data stable, req_ready=0, cell_en=0 throughout. A request held on req_valid is accepted one cycle after the rsp handshake.
- Flush during ISSUE2 of MULXUU -> no rsp_valid, state IDLE next cycle, req_ready=1. A following MUL 3*5 returns 0x0000000F.
- Reset asserted asynchronously in CAP1 -> rsp_valid, cell_en and rsp_data read 0 before the next clk edge. After release, req_ready=1 and the block is fully functional.
